data_transceiver: RTL and testbench

Parallel-to-serial transmit stage driven by the controller's `SampleData`/`TransferData` strobes. It captures a `DATA_WIDTH`-bit word from memory read data on `SampleData`. On `TransferData` it shifts the word out MSB-first, one bit per clock. After the last bit it returns a one-cycle `TransferDone` pulse to the controller's `TransferDone` input.

---
 rtl/data_transceiver.sv | 153 +++++++++++++++
 tb/tb_data_transceiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_transceiver.sv
// data_transceiver: parallel-to-serial transmit stage.
// Captures a DATA_WIDTH-bit word on SampleData, shifts it out MSB-first on
// TransferData (one bit per clock), then pulses TransferDone for one cycle.
// Optional feature macro: DATA_TRANSCEIVER_PARITY_EN appends an even-parity
// bit after the data bits.
// All outputs are registered; no combinational input-to-output path.

module data_transceiver #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SampleData,
  input  logic                  TransferData,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  DataOut,
  output logic                  OutputValid,
  output logic                  TransferDone
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

`ifdef DATA_TRANSCEIVER_PARITY_EN
  localparam int unsigned NumBits = DATA_WIDTH + 1;
  // Counter value at which the parity bit is emitted (all data bits already out).
  localparam logic [CntW-1:0] ParCnt = CntW'(DATA_WIDTH - 1);
`else
  localparam int unsigned NumBits = DATA_WIDTH;
`endif

  // The MSB goes out on the edge that enters SHIFT, so the counter (cleared on
  // entry) tracks the bits sent after the first one; this value ends the shift.
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBits - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoaded,
    StShift,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

`ifdef DATA_TRANSCEIVER_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef DATA_TRANSCEIVER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
`ifdef DATA_TRANSCEIVER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state logic; registered outputs are computed for the cycle after the edge.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    data_out_d = 1'b0;
    valid_d    = 1'b0;
    done_d     = 1'b0;
`ifdef DATA_TRANSCEIVER_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        // A simultaneous TransferData is dropped: there is nothing to send yet.
        if (SampleData) begin
          shift_d = DataIn;
`ifdef DATA_TRANSCEIVER_PARITY_EN
          parity_d = ^DataIn;
`endif
          state_d = StLoaded;
        end
      end

      StLoaded: begin
        if (TransferData) begin
          // Transfer wins over a simultaneous resample; emit the MSB right away.
          data_out_d = shift_q[DATA_WIDTH-1];
          valid_d    = 1'b1;
          shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
          cnt_d      = '0;
          state_d    = StShift;
        end else if (SampleData) begin
          shift_d = DataIn;
`ifdef DATA_TRANSCEIVER_PARITY_EN
          parity_d = ^DataIn;
`endif
        end
      end

      StShift: begin
        if (cnt_q == LastCnt) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          valid_d = 1'b1;
          cnt_d   = cnt_q + CntW'(1);
`ifdef DATA_TRANSCEIVER_PARITY_EN
          if (cnt_q == ParCnt) begin
            data_out_d = parity_q;
          end else begin
            data_out_d = shift_q[DATA_WIDTH-1];
            shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
          end
`else
          data_out_d = shift_q[DATA_WIDTH-1];
          shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
`endif
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign DataOut      = data_out_q;
  assign OutputValid  = valid_q;
  assign TransferDone = done_q;

endmodule

// File: tb/tb_data_transceiver.sv
// tb_data_transceiver: randomized and directed stimulus for data_transceiver,
// checked cycle by cycle against a queue-based transaction model.
// Honours DATA_TRANSCEIVER_PARITY_EN to match the DUT build.

module tb_data_transceiver;

  localparam int unsigned W = 8;
`ifdef DATA_TRANSCEIVER_PARITY_EN
  localparam int unsigned Par = 1;
`else
  localparam int unsigned Par = 0;
`endif

  logic         Clk;
  logic         Reset;
  logic         SampleData;
  logic         TransferData;
  logic [W-1:0] DataIn;
  logic         DataOut;
  logic         OutputValid;
  logic         TransferDone;

  data_transceiver #(
    .DATA_WIDTH(W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SampleData   (SampleData),
    .TransferData (TransferData),
    .DataIn       (DataIn),
    .DataOut      (DataOut),
    .OutputValid  (OutputValid),
    .TransferDone (TransferDone)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Transaction model: one expected output triple per future cycle.
  typedef struct packed {
    logic d;
    logic v;
    logic t;
  } exp_t;

  exp_t         m_q[$];
  exp_t         m_exp;
  logic [W-1:0] m_word;
  bit           m_has;

  task automatic model_step(input logic rst, input logic smp, input logic xfr,
                            input logic [W-1:0] din);
    if (rst) begin
      m_q.delete();
      m_has = 1'b0;
      m_exp = '0;
    end else if (m_q.size() > 0) begin
      // Busy transmitting (or in the done/turnaround cycle): strobes ignored.
      m_exp = m_q.pop_front();
    end else begin
      m_exp = '0;
      if (m_has && xfr) begin
        for (int i = W - 1; i >= 0; i--) m_q.push_back('{d: m_word[i], v: 1'b1, t: 1'b0});
        if (Par != 0) m_q.push_back('{d: ^m_word, v: 1'b1, t: 1'b0});
        m_q.push_back('{d: 1'b0, v: 1'b0, t: 1'b1});
        // Edge ending the done cycle cannot accept a strobe.
        m_q.push_back('{d: 1'b0, v: 1'b0, t: 1'b0});
        m_exp = m_q.pop_front();
        m_has = 1'b0;
      end else if (smp) begin
        m_word = din;
        m_has  = 1'b1;
      end
    end
  endtask

  // Observed serial stream, reassembled per transfer.
  logic [31:0] ser_word  = '0;
  int unsigned ser_len   = 0;
  logic [31:0] last_word = '0;
  int unsigned last_len  = 0;
  int unsigned done_cnt  = 0;

  function automatic logic [31:0] exp_serial(input logic [W-1:0] w);
    if (Par != 0) return 32'({w, ^w});
    return 32'(w);
  endfunction

  task automatic cycle(input logic rst, input logic smp, input logic xfr, input logic [W-1:0] din);
    Reset        = rst;
    SampleData   = smp;
    TransferData = xfr;
    DataIn       = din;
    @(posedge Clk);
    model_step(rst, smp, xfr, din);
    #1;
    check_value("DataOut", 32'(DataOut), 32'(m_exp.d));
    check_value("OutputValid", 32'(OutputValid), 32'(m_exp.v));
    check_value("TransferDone", 32'(TransferDone), 32'(m_exp.t));
    if (rst) begin
      ser_word = '0;
      ser_len  = 0;
    end else begin
      if (OutputValid) begin
        ser_word = {ser_word[30:0], DataOut};
        ser_len++;
      end
      if (TransferDone) begin
        last_word = ser_word;
        last_len  = ser_len;
        done_cnt++;
        ser_word  = '0;
        ser_len   = 0;
      end
    end
  endtask

  task automatic run_idle(input int unsigned n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, W'($urandom));
  endtask

  // Sample, idle one cycle, transfer, then drain; check the reassembled word.
  task automatic send_word(input string tag, input logic [W-1:0] w);
    int unsigned d0;
    d0 = done_cnt;
    cycle(1'b0, 1'b1, 1'b0, w);
    cycle(1'b0, 1'b0, 1'b0, W'($urandom));
    cycle(1'b0, 1'b0, 1'b1, W'($urandom));
    run_idle(W + Par + 3);
    check_value({tag, "_word"}, last_word, exp_serial(w));
    check_value({tag, "_len"}, 32'(last_len), 32'(W + Par));
    check_value({tag, "_done"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    int unsigned d0;
    Reset        = 1'b1;
    SampleData   = 1'b0;
    TransferData = 1'b0;
    DataIn       = '0;

    // Reset with random strobes, then a lone TransferData must do nothing.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'($urandom), 1'($urandom), W'($urandom));
    cycle(1'b0, 1'b0, 1'b1, W'($urandom));
    run_idle(W + 3);
    check_value("reset_no_done", 32'(done_cnt), 32'd0);

    // Basic shift.
    send_word("basic_a5", 8'hA5);

    // Resample, then simultaneous strobes: transfer wins, 8'h00 not loaded.
    d0 = done_cnt;
    cycle(1'b0, 1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, 1'b0, 8'hF0);
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    run_idle(W + Par + 3);
    check_value("resample_word", last_word, exp_serial(8'hF0));
    check_value("resample_done", 32'(done_cnt), 32'(d0 + 1));

    // Strobes in the middle of a shift are ignored.
    d0 = done_cnt;
    cycle(1'b0, 1'b1, 1'b0, 8'h81);
    cycle(1'b0, 1'b0, 1'b1, W'($urandom));
    run_idle(3);
    cycle(1'b0, 1'b1, 1'b0, 8'hFF);
    cycle(1'b0, 1'b0, 1'b1, W'($urandom));
    run_idle(W + Par + 3);
    check_value("midstrobe_word", last_word, exp_serial(8'h81));
    check_value("midstrobe_done", 32'(done_cnt), 32'(d0 + 1));

    // Reset during bit 4, then a fresh transfer.
    d0 = done_cnt;
    cycle(1'b0, 1'b1, 1'b0, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1, W'($urandom));
    run_idle(4);
    cycle(1'b1, 1'b0, 1'b0, W'($urandom));
    run_idle(W + Par + 3);
    check_value("midreset_no_done", 32'(done_cnt), 32'(d0));
    send_word("after_reset_5a", 8'h5A);

    // Words with even and odd parity.
    send_word("par_a5", 8'hA5);
    send_word("par_07", 8'h07);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), W'($urandom));
    end
    run_idle(W + Par + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
